// File: rtl/usb_seq_pkg.sv
// Shared definitions for the USB FIFO sequencer: state codes, field widths,
// parameter limits and the phase-counter load helper.
package usb_seq_pkg;

  localparam int TAG_W = 4;
  localparam int CNT_W = 4;
  localparam int IDX_W = 4;

  localparam int SW_WIDTH_MIN = 4;
  localparam int SW_WIDTH_MAX = 60;
  localparam int PHASE_MIN    = 1;
  localparam int PHASE_MAX    = 15;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RD_STROBE = 3'd1,
    ST_RD_END    = 3'd2,
    ST_WR_SETUP  = 3'd3,
    ST_WR_STROBE = 3'd4,
    ST_WR_HOLD   = 3'd5,
    ST_WR_WAIT   = 3'd6
  } seq_state_e;

  // A phase of N cycles loads N-1; the timer reports done on its last cycle.
  function automatic logic [CNT_W-1:0] phase_load(input int cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/usb_strobe_timer.sv
// Loadable down-counter that times every strobe phase; done is high while
// the count is zero, and the count never wraps below zero.
module usb_strobe_timer
  import usb_seq_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             done_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == '0);

endmodule

// File: rtl/usb_fifo_sequencer.sv
// FT245-style FIFO sequencer: single-byte command reads and nibble-tagged
// switch-report frames. Optional USB_SEQ_AUTO_REPORT_EN sends a frame on switch change.
module usb_fifo_sequencer
  import usb_seq_pkg::*;
#(
  parameter int SW_WIDTH = 16,
  parameter int RD_PULSE = 2,
  parameter int WR_SETUP = 1,
  parameter int WR_PULSE = 2,
  parameter int WR_HOLD  = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                rxf_n,
  input  logic                txe_n,
  input  logic                panel_select_request,
  input  logic [SW_WIDTH-1:0] panel_switches,
  input  logic [7:0]          data_in,
  output logic [7:0]          data_out,
  output logic                data_out_enable,
  output logic                rd_n,
  output logic                wr_n,
  output logic                command_write_enable,
  output logic [7:0]          command_data,
  output logic [2:0]          state_out
);

  localparam int NIB = SW_WIDTH / 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  if ((SW_WIDTH % 4) != 0 || SW_WIDTH < SW_WIDTH_MIN || SW_WIDTH > SW_WIDTH_MAX) begin : g_bad_sw
    $error("usb_fifo_sequencer: SW_WIDTH must be a multiple of 4 in 4..60");
  end
  if (RD_PULSE < PHASE_MIN || RD_PULSE > PHASE_MAX || WR_SETUP < PHASE_MIN ||
      WR_SETUP > PHASE_MAX || WR_PULSE < PHASE_MIN || WR_PULSE > PHASE_MAX ||
      WR_HOLD < PHASE_MIN || WR_HOLD > PHASE_MAX) begin : g_bad_phase
    $error("usb_fifo_sequencer: phase lengths must be in 1..15");
  end

  seq_state_e          state_q, state_d;
  logic                pending_q, pending_d;
  logic [SW_WIDTH-1:0] snapshot_q, snapshot_d;
  logic [IDX_W-1:0]    byte_idx_q, byte_idx_d;
  logic [7:0]          cmd_q, cmd_d;

  logic             frame_start;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_done;

  usb_strobe_timer u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  always_comb begin
    state_d     = state_q;
    byte_idx_d  = byte_idx_q;
    snapshot_d  = snapshot_q;
    cmd_d       = cmd_q;
    frame_start = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    case (state_q)
      ST_IDLE: begin
        // A pending read always wins over a pending report.
        if (!rxf_n) begin
          state_d  = ST_RD_STROBE;
          tmr_load = 1'b1;
          tmr_val  = phase_load(RD_PULSE);
        end else if (pending_q && !txe_n) begin
          state_d     = ST_WR_SETUP;
          tmr_load    = 1'b1;
          tmr_val     = phase_load(WR_SETUP);
          byte_idx_d  = '0;
          snapshot_d  = panel_switches;
          frame_start = 1'b1;
        end
      end
      ST_RD_STROBE: begin
        if (tmr_done) begin
          cmd_d   = data_in;
          state_d = ST_RD_END;
        end
      end
      ST_RD_END: begin
        state_d = ST_IDLE;
      end
      ST_WR_SETUP: begin
        if (tmr_done) begin
          state_d  = ST_WR_STROBE;
          tmr_load = 1'b1;
          tmr_val  = phase_load(WR_PULSE);
        end
      end
      ST_WR_STROBE: begin
        if (tmr_done) begin
          state_d  = ST_WR_HOLD;
          tmr_load = 1'b1;
          tmr_val  = phase_load(WR_HOLD);
        end
      end
      ST_WR_HOLD: begin
        if (tmr_done) begin
          if (byte_idx_q == LAST_IDX) begin
            state_d = ST_IDLE;
          end else begin
            byte_idx_d = byte_idx_q + IDX_W'(1);
            if (!txe_n) begin
              state_d  = ST_WR_SETUP;
              tmr_load = 1'b1;
              tmr_val  = phase_load(WR_SETUP);
            end else begin
              state_d = ST_WR_WAIT;
            end
          end
        end
      end
      ST_WR_WAIT: begin
        if (!txe_n) begin
          state_d  = ST_WR_SETUP;
          tmr_load = 1'b1;
          tmr_val  = phase_load(WR_SETUP);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Request set has priority over the start-of-frame clear, so a request
  // held through the start cycle still queues exactly one more frame.
`ifdef USB_SEQ_AUTO_REPORT_EN
  logic auto_set;
  assign auto_set  = (state_q == ST_IDLE) && !frame_start && (panel_switches != snapshot_q);
  assign pending_d = panel_select_request | auto_set | (pending_q & ~frame_start);
`else
  assign pending_d = panel_select_request | (pending_q & ~frame_start);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      pending_q  <= 1'b0;
      snapshot_q <= '0;
      byte_idx_q <= '0;
      cmd_q      <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      snapshot_q <= snapshot_d;
      byte_idx_q <= byte_idx_d;
      cmd_q      <= cmd_d;
    end
  end

  logic [3:0]       cur_nib;
  logic [TAG_W-1:0] cur_tag;

  always_comb begin
    cur_nib = '0;
    for (int i = 0; i < NIB; i++) begin
      if (byte_idx_q == IDX_W'(i)) begin
        cur_nib = snapshot_q[4*i +: 4];
      end
    end
  end

  assign cur_tag = TAG_W'(byte_idx_q + IDX_W'(1));

  // Strobes decode straight from the state register so reset reaches the pins at once.
  always_comb begin
    rd_n                 = (state_q != ST_RD_STROBE);
    wr_n                 = (state_q != ST_WR_STROBE);
    command_write_enable = (state_q == ST_RD_END);
    data_out_enable      = (state_q == ST_WR_SETUP) || (state_q == ST_WR_STROBE) ||
                           (state_q == ST_WR_HOLD);
    data_out             = data_out_enable ? {cur_tag, cur_nib} : 8'h00;
  end

  assign command_data = cmd_q;
  assign state_out    = state_q;

endmodule

// File: doc/usb_fifo_sequencer.md
USB_FIFO_SEQUENCER -- requirements
Module: usb_fifo_sequencer

Interface
REQ-001 Parameter SW_WIDTH, default 16: panel switch width; SHALL be a multiple of 4, range 4..60.
REQ-002 Parameter RD_PULSE, default 2: rd_n low cycles per read, range 1..15.
REQ-003 Parameter WR_SETUP, default 1: data-valid cycles before wr_n falls, range 1..15.
REQ-004 Parameter WR_PULSE, default 2: wr_n low cycles per byte, range 1..15.
REQ-005 Parameter WR_HOLD, default 2: data-valid cycles after wr_n rises, range 1..15.
REQ-006 Ports, in order:
- clk  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rxf_n  in  1  FIFO has receive data (low).
- txe_n  in  1  FIFO can accept a byte (low).
- panel_select_request  in  1  request a switch report.
- panel_switches  in  SW_WIDTH  switch bank.
- data_in  in  8  FIFO read data.
- data_out  out  8  FIFO write data.
- data_out_enable  out  1  drive data bus.
- rd_n  out  1  FIFO read strobe.
- wr_n  out  1  FIFO write strobe.
- command_write_enable  out  1  one-cycle strobe: command_data valid.
- command_data  out  8  last byte read.
- state_out  out  3  current state code.

Function
REQ-007 States and codes: IDLE=0, RD_STROBE=1, RD_END=2, WR_SETUP=3, WR_STROBE=4, WR_HOLD=5, WR_WAIT=6.
REQ-008 A frame SHALL be NIB=SW_WIDTH/4 bytes; byte k (0-based) = {k+1 as 4 bits, snapshot[4k+3:4k]}, sent k ascending.
REQ-009 A rising-independent level of panel_select_request SHALL set a pending flag, in any state; the flag clears when a frame starts from IDLE.
REQ-010 IDLE: rxf_n low -> RD_STROBE; else pending and txe_n low -> WR_SETUP, byte 0, panel_switches snapshotted that edge; else stay. Read takes priority over write.
REQ-011 RD_STROBE: rd_n=0 for RD_PULSE cycles; data_in registered into command_data on its last cycle; then RD_END.
REQ-012 RD_END: one cycle, rd_n=1, command_write_enable=1; then IDLE.
REQ-013 WR_SETUP: WR_SETUP cycles, data_out_enable=1, wr_n=1; then WR_STROBE.
REQ-014 WR_STROBE: WR_PULSE cycles, wr_n=0, data_out_enable=1; then WR_HOLD.
REQ-015 WR_HOLD: WR_HOLD cycles, wr_n=1, data_out_enable=1; then IDLE if last byte, else WR_SETUP (txe_n low) or WR_WAIT (txe_n high).
REQ-016 WR_WAIT: data_out_enable=0, wr_n=1; leave to WR_SETUP on first cycle txe_n low; reads SHALL NOT interleave within a frame.
REQ-017 data_out SHALL equal the current byte while data_out_enable=1, else 8'h00; it SHALL NOT change mid-byte even if panel_switches changes.
REQ-018 Request arriving during a frame SHALL produce exactly one further frame after return to IDLE.
REQ-019 Phase counter 4 bits, byte index 4 bits; no wrap beyond configured limits.

Reset
REQ-020 reset_n low, any state, SHALL immediately force: IDLE, rd_n=1, wr_n=1, data_out_enable=0, data_out=0, command_write_enable=0, command_data=0, pending=0, snapshot=0, counters=0, state_out=0.

Configuration
REQ-021 Macro USB_SEQ_AUTO_REPORT_EN defined: in IDLE, panel_switches differing from last sent snapshot SHALL also set pending. Undefined: frames only on panel_select_request; no comparison logic.

Structure
REQ-022 State codes, nibble tag width and parameter limits SHALL live in shared package usb_seq_pkg.
REQ-023 One sub-module usb_strobe_timer (loadable down-counter with done flag) SHALL time all phases.

Verification
REQ-024 Defaults, rxf_n low 1 cycle, data_in=8'hA5 -> rd_n low 2 cycles, then command_write_enable 1 cycle, command_data=8'hA5.
REQ-025 Defaults, switches=16'hBEEF, request pulse, txe_n low -> bytes 8'h1F,8'h2E,8'h3E,8'h4B, each wr_n low 2 cycles after 1 setup cycle.
REQ-026 txe_n high after byte 1 for 10 cycles -> WR_WAIT (state_out=6) 10 cycles, data_out_enable=0, then bytes 2..4 unchanged.
REQ-027 rxf_n low and request same cycle -> read completes first, then full frame.
REQ-028 reset_n low during WR_STROBE -> wr_n=1, data_out_enable=0 same cycle; no frame after release without new request.
REQ-029 SW_WIDTH=8, macro defined, switches 8'h00->8'h31, no request -> frame 8'h11,8'h23.
